p2_decode_p5_write_back: RTL

Decode, register-file and phase-sequencing stage of the SIMPLE 16-bit multicycle processor. It consumes `instruction_register_wire`, `memory_data_register_wire` and the execute result from the fetch/memory stage. It drives the 3-bit `phase_counter` and every control strobe that stage needs. It holds the eight 16-bit general registers: operands are read in phase 2 and results are written back in phase 5.

---
 rtl/p2_decode_p5_write_back.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/p2_decode_p5_write_back.sv
// Decode, register-file and phase-sequencing stage of the SIMPLE 16-bit
// multicycle processor. Decodes the IR, holds the eight general registers,
// runs the five-phase instruction sequence and drives the control strobes
// consumed by the fetch/memory stage.
//
// state     | meaning
// ----------+---------------------------------------------------------
// PH_IDLE   | halted, waiting for run (phase_counter = 0)
// PH_FETCH  | phase 1, fetch stage loads IR
// PH_DECODE | phase 2, operands read; latched into data_register_a/b at exit
// PH_EXEC   | phase 3, ALU result valid; flags latched at exit
// PH_MEM    | phase 4, memory access for LD/ST
// PH_WB     | phase 5, register write-back at exit; HLT returns to idle
module p2_decode_p5_write_back (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instruction_register,
  input  logic [15:0] memory_data_register,
  input  logic [15:0] data_for_res,
  input  logic [3:0]  alu_flags,
  output logic [2:0]  phase_counter,
  output logic [15:0] data_register_a,
  output logic [15:0] data_register_b,
  output logic [15:0] immediate,
  output logic [3:0]  alu_op,
  output logic        op_branch,
  output logic        op_mdr,
  output logic        op_mem_write,
  output logic        op_mem_src,
  output logic [3:0]  flags,
  output logic        halted
);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_FETCH  = 3'd1,
    PH_DECODE = 3'd2,
    PH_EXEC   = 3'd3,
    PH_MEM    = 3'd4,
    PH_WB     = 3'd5
  } phase_e;

  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_IN  = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  phase_e      phase_q, phase_d;
  logic [15:0] regs_q [8];
  logic [15:0] reg_a_q, reg_b_q;
  logic [3:0]  flags_q;

  // IR fields
  logic [1:0]  ir_class;
  logic [2:0]  ir_ra;
  logic [2:0]  ir_rb;
  logic [3:0]  ir_op;
  logic [3:0]  ir_d;
  logic [7:0]  ir_disp;

  assign ir_class = instruction_register[15:14];
  assign ir_ra    = instruction_register[13:11];
  assign ir_rb    = instruction_register[10:8];
  assign ir_op    = instruction_register[7:4];
  assign ir_d     = instruction_register[3:0];
  assign ir_disp  = instruction_register[7:0];

  // Instruction class decode
  logic is_arith, is_ld, is_st, is_li, is_b, is_bcond;
  logic is_in, is_hlt, arith_sets_flags, arith_writes_res;

  // Instruction decode from the IR class, selector and op fields
  always_comb begin
    is_arith         = 1'b0;
    is_ld            = 1'b0;
    is_st            = 1'b0;
    is_li            = 1'b0;
    is_b             = 1'b0;
    is_bcond         = 1'b0;
    is_in            = 1'b0;
    is_hlt           = 1'b0;
    arith_sets_flags = 1'b0;
    arith_writes_res = 1'b0;
    unique case (ir_class)
      2'b11: begin
        is_arith         = 1'b1;
        is_in            = (ir_op == OP_IN);
        is_hlt           = (ir_op == OP_HLT);
        arith_sets_flags = (ir_op <= 4'b1011);
        // ADD..XOR, MOV and the four shifts produce a result; CMP and the
        // undefined 0111 only affect flags.
        arith_writes_res = (ir_op < OP_CMP) || (ir_op == OP_MOV) ||
                           (ir_op[3:2] == 2'b10);
      end
      2'b00: is_ld = 1'b1;
      2'b01: is_st = 1'b1;
      2'b10: begin
        is_li    = (ir_ra == 3'b000);
        is_b     = (ir_ra == 3'b100);
        is_bcond = (ir_ra == 3'b111);
      end
      default: ;
    endcase
  end

  // Immediate extension and ALU op select
  always_comb begin
    if (is_arith) begin
      immediate = {12'd0, ir_d};
      alu_op    = ir_op;
    end else begin
      immediate = {{8{ir_disp[7]}}, ir_disp};
      alu_op    = 4'b0000;
    end
  end

  // Branch decision from IR and latched flags {S,Z,C,V}
  logic flag_s, flag_z, flag_v;
  assign flag_s = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];

  always_comb begin
    op_branch = 1'b0;
    if (is_b) begin
      op_branch = 1'b1;
    end else if (is_bcond) begin
      unique case (ir_rb)
        3'b000:  op_branch = flag_z;
        3'b001:  op_branch = flag_s ^ flag_v;
        3'b010:  op_branch = flag_z | (flag_s ^ flag_v);
        3'b011:  op_branch = ~flag_z;
        default: op_branch = 1'b0;
      endcase
    end
  end

  // Memory and MDR strobes decoded straight from the phase register
  always_comb begin
    op_mem_src   = 1'b0;
    op_mem_write = 1'b0;
    op_mdr       = 1'b0;
    if (phase_q == PH_MEM) begin
      op_mem_src   = is_ld | is_st;
      op_mem_write = is_st;
    end
    if (is_in && (phase_q >= PH_DECODE) && (phase_q <= PH_WB)) begin
      op_mdr = 1'b1;
    end
  end

  // Phase sequencing: run only matters while idle; HLT ends in idle
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PH_IDLE:   if (run) phase_d = PH_FETCH;
      PH_FETCH:  phase_d = PH_DECODE;
      PH_DECODE: phase_d = PH_EXEC;
      PH_EXEC:   phase_d = PH_MEM;
      PH_MEM:    phase_d = PH_WB;
      PH_WB:     phase_d = is_hlt ? PH_IDLE : PH_FETCH;
      default:   phase_d = PH_IDLE;
    endcase
  end

  // Phase state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) phase_q <= PH_IDLE;
    else       phase_q <= phase_d;
  end

  // Write-back port selection; at most one register written per instruction
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = 3'd0;
    wb_data = data_for_res;
    if (is_arith && arith_writes_res) begin
      wb_en   = 1'b1;
      wb_addr = ir_rb;
    end else if (is_arith && is_in) begin
      wb_en   = 1'b1;
      wb_addr = ir_rb;
      wb_data = memory_data_register;
    end else if (is_ld) begin
      wb_en   = 1'b1;
      wb_addr = ir_ra;
      wb_data = memory_data_register;
    end else if (is_li) begin
      wb_en   = 1'b1;
      wb_addr = ir_rb;
    end
  end

  // Register file: written only on the exit edge of phase 5
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (phase_q == PH_WB && wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Operand latches loaded on the exit edge of phase 2
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else if (phase_q == PH_DECODE) begin
      reg_a_q <= regs_q[ir_ra];
      reg_b_q <= regs_q[ir_rb];
    end
  end

  // Flags latched on the exit edge of phase 3 for flag-setting ALU ops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (phase_q == PH_EXEC && is_arith && arith_sets_flags) begin
      flags_q <= alu_flags;
    end
  end

  assign phase_counter   = phase_q;
  assign data_register_a = reg_a_q;
  assign data_register_b = reg_b_q;
  assign flags           = flags_q;
  assign halted          = (phase_q == PH_IDLE);

endmodule
